// File: rtl/reg_bank_scanner_pkg.sv
// Shared types and default sizing for the register bank scanner.
// Scanner FSM encoding is fixed: IDLE=0, PRESENT=1.
package reg_bank_scanner_pkg;

   localparam int DEF_WIDTH  = 8;
   localparam int DEF_DEPTH  = 8;
   localparam int DEF_ADDR_W = 3;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_PRESENT = 1'b1
   } scan_state_e;

endpackage

// File: rtl/reg_bank_scanner_if.sv
// Write port plus valid/ready read stream of the register bank scanner.
// master drives writes, Start and Ready; slave is the scanner itself.
interface reg_bank_scanner_if
   import reg_bank_scanner_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int ADDR_W = DEF_ADDR_W
);

   logic              WE;
   logic [ADDR_W-1:0] WAddr;
   logic [WIDTH-1:0]  D;
   logic              Start;
   logic              Ready;
   logic [WIDTH-1:0]  Q;
   logic              Valid;
   logic              Last;
   logic              Busy;
   logic              Done;

   modport master (
      output WE, WAddr, D, Start, Ready,
      input  Q, Valid, Last, Busy, Done
   );

   modport slave (
      input  WE, WAddr, D, Start, Ready,
      output Q, Valid, Last, Busy, Done
   );

endinterface

// File: rtl/reg_bank_storage.sv
// DEPTH x WIDTH register array: sync reset, one write port, one combinational read port.
// A write landing on the address being read this cycle is forwarded to rd_dat.
module reg_bank_storage #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdat,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_dat
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             wr_ok;

   // Out-of-range addresses only exist for non-power-of-2 DEPTH; drop them.
   assign wr_ok = we && (int'(waddr) < DEPTH);

   always_comb begin
      mem_d = mem_q;
      if (wr_ok) begin
         mem_d[waddr] = wdat;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q <= '{default: '0};
      end else begin
         mem_q <= mem_d;
      end
   end

   always_comb begin
      rd_dat = mem_q[rd_addr];
      if (wr_ok && (waddr == rd_addr)) begin
         rd_dat = wdat;
      end
   end

endmodule

// File: rtl/reg_bank_scanner.sv
// Register bank with a scanner that streams every entry in address order on Start.
// One-cycle Start-to-Valid latency, one word per cycle; Ready low freezes a captured Q.
module reg_bank_scanner
   import reg_bank_scanner_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              Clock,
   input  logic              Reset,
   reg_bank_scanner_if.slave bus
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   scan_state_e       state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [WIDTH-1:0]  q_q, q_d;
   logic              last_q, last_d;
   logic              done_q, done_d;

   logic              at_last;
   logic              accept;
   logic [ADDR_W-1:0] addr_nxt;
   logic [ADDR_W-1:0] rd_addr;
   logic [WIDTH-1:0]  rd_dat;

   reg_bank_storage #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_storage (
      .clk     (Clock),
      .rst     (Reset),
      .we      (bus.WE),
      .waddr   (bus.WAddr),
      .wdat    (bus.D),
      .rd_addr (rd_addr),
      .rd_dat  (rd_dat)
   );

   assign at_last = (addr_q == LAST_ADDR);
   assign accept  = (state_q == ST_PRESENT) && bus.Ready;

   // Guarded increment so the scan address never wraps arithmetically.
   assign addr_nxt = at_last ? '0 : addr_q + ADDR_W'(1);
   assign rd_addr  = (state_q == ST_IDLE) ? '0 : addr_nxt;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.Start) begin
               state_d = ST_PRESENT;
            end
         end
         ST_PRESENT: begin
            if (accept && at_last) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      addr_d = addr_q;
      q_d    = q_q;
      last_d = last_q;
      done_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            last_d = 1'b0;
            if (bus.Start) begin
               addr_d = '0;
               q_d    = rd_dat;
               last_d = (LAST_ADDR == '0);
            end
         end
         ST_PRESENT: begin
            if (accept) begin
               if (at_last) begin
                  addr_d = '0;
                  last_d = 1'b0;
                  done_d = 1'b1;
               end else begin
                  addr_d = addr_nxt;
                  q_d    = rd_dat;
                  last_d = (addr_nxt == LAST_ADDR);
               end
            end
         end
         default: begin
            addr_d = '0;
            last_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         addr_q <= '0;
         q_q    <= '0;
         last_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         addr_q <= addr_d;
         q_q    <= q_d;
         last_q <= last_d;
         done_q <= done_d;
      end
   end

   assign bus.Q     = q_q;
   assign bus.Valid = (state_q == ST_PRESENT);
   assign bus.Busy  = (state_q == ST_PRESENT);
   assign bus.Last  = last_q;
   assign bus.Done  = done_q;

endmodule

// File: tb/tb_reg_bank_scanner.sv
// Directed scenarios plus random traffic, every cycle compared against a
// bank-and-index reference model of the scanner.
module tb_reg_bank_scanner;

   localparam int WIDTH  = 8;
   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [WIDTH-1:0] bank_m [DEPTH];
   bit               m_busy = 1'b0;
   bit               m_last = 1'b0;
   bit               m_done = 1'b0;
   int               m_idx  = 0;
   logic [WIDTH-1:0] m_q    = '0;

   reg_bank_scanner_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

   reg_bank_scanner #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) dut (
      .Clock (clk),
      .Reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: a scan is "busy + current index"; each accepted word moves the index on.
   task automatic model_step();
      int wa;
      wa = int'(bus.WAddr);
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) bank_m[i] = '0;
         m_busy = 1'b0;
         m_idx  = 0;
         m_q    = '0;
         m_last = 1'b0;
         m_done = 1'b0;
         return;
      end
      m_done = 1'b0;
      if (!m_busy) begin
         if (bus.Start) begin
            m_busy = 1'b1;
            m_idx  = 0;
            m_q    = (bus.WE && wa == 0) ? bus.D : bank_m[0];
         end
      end else if (bus.Ready) begin
         if (m_idx == DEPTH - 1) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            m_idx  = 0;
         end else begin
            m_idx = m_idx + 1;
            m_q   = (bus.WE && wa == m_idx) ? bus.D : bank_m[m_idx];
         end
      end
      m_last = m_busy && (m_idx == DEPTH - 1);
      if (bus.WE && wa < DEPTH) bank_m[wa] = bus.D;
   endtask

   task automatic check_model();
      check_val("valid", 32'(bus.Valid), 32'(m_busy));
      check_val("busy",  32'(bus.Busy),  32'(m_busy));
      check_val("last",  32'(bus.Last),  32'(m_last));
      check_val("done",  32'(bus.Done),  32'(m_done));
      check_val("q",     32'(bus.Q),     32'(m_q));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_model();
   endtask

   task automatic run_until_done(input string tag);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         tick();
         if (bus.Done) seen = 1'b1;
      end
      check_val({tag, "_done_seen"}, 32'(seen), 32'd1);
   endtask

   initial begin
      int n_done;
      bus.WE    = 1'b0;
      bus.WAddr = '0;
      bus.D     = '0;
      bus.Start = 1'b0;
      bus.Ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) bank_m[i] = 'x;

      // Reset state
      rst = 1'b1;
      tick();
      check_val("rst_valid", 32'(bus.Valid), 32'd0);
      check_val("rst_busy",  32'(bus.Busy),  32'd0);
      check_val("rst_done",  32'(bus.Done),  32'd0);
      check_val("rst_q",     32'(bus.Q),     32'd0);
      rst = 1'b0;

      // Scan of a freshly reset bank
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         if (c <= 8) begin
            check_val("p1_valid", 32'(bus.Valid), 32'd1);
            check_val("p1_q",     32'(bus.Q),     32'd0);
            check_val("p1_last",  32'(bus.Last),  32'(c == 8));
         end else begin
            check_val("p1_done",  32'(bus.Done),  32'd1);
            check_val("p1_valid_end", 32'(bus.Valid), 32'd0);
         end
         if (c < 9) tick();
      end

      // Fill A0..A7 then stream it out
      for (int i = 0; i < DEPTH; i++) begin
         bus.WE    = 1'b1;
         bus.WAddr = ADDR_W'(i);
         bus.D     = WIDTH'(8'hA0 + i);
         tick();
      end
      bus.WE    = 1'b0;
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      for (int c = 0; c < DEPTH; c++) begin
         check_val("p2_q", 32'(bus.Q), 32'(8'hA0 + c));
         tick();
      end
      check_val("p2_done", 32'(bus.Done), 32'd1);
      tick();
      check_val("p2_busy_after", 32'(bus.Busy), 32'd0);

      // Backpressure with writes during the stall
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      tick();
      tick();
      check_val("p3_q_a2", 32'(bus.Q), 32'h0A2);
      bus.Ready = 1'b0;
      bus.WE = 1'b1; bus.WAddr = 3'd2; bus.D = 8'h55;
      tick();
      check_val("p3_stall_q", 32'(bus.Q), 32'h0A2);
      bus.WAddr = 3'd3; bus.D = 8'h66;
      tick();
      check_val("p3_stall_q", 32'(bus.Q), 32'h0A2);
      bus.WE = 1'b0;
      tick();
      check_val("p3_stall_q",     32'(bus.Q),     32'h0A2);
      check_val("p3_stall_valid", 32'(bus.Valid), 32'd1);
      bus.Ready = 1'b1;
      tick();
      check_val("p3_q_66", 32'(bus.Q), 32'h066);
      run_until_done("p3");

      // Write-through on the Start cycle
      bus.Start = 1'b1;
      bus.WE = 1'b1; bus.WAddr = 3'd0; bus.D = 8'h3C;
      tick();
      bus.Start = 1'b0;
      bus.WE    = 1'b0;
      check_val("p4_q_3c", 32'(bus.Q), 32'h03C);

      // Start mid-scan is ignored; Start in the Done cycle is honoured
      for (int k = 0; k < 4; k++) tick();
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      n_done = 0;
      for (int k = 0; k < 12 && n_done == 0; k++) begin
         tick();
         if (bus.Done) n_done++;
      end
      check_val("p5_single_done", 32'(n_done), 32'd1);
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      check_val("p5_restart_valid", 32'(bus.Valid), 32'd1);
      check_val("p5_restart_q",     32'(bus.Q),     32'h03C);

      // Reset mid-scan together with Start
      for (int k = 0; k < 5; k++) tick();
      bus.Start = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.Start = 1'b0;
      check_val("p6_valid", 32'(bus.Valid), 32'd0);
      check_val("p6_busy",  32'(bus.Busy),  32'd0);
      check_val("p6_done",  32'(bus.Done),  32'd0);
      tick();
      check_val("p6_start_ignored", 32'(bus.Busy), 32'd0);
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      for (int c = 0; c < DEPTH; c++) begin
         check_val("p6_cleared", 32'(bus.Q), 32'd0);
         tick();
      end

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         rst       = ($urandom_range(0, 255) == 0);
         bus.WE    = 1'($urandom_range(0, 1));
         bus.WAddr = ADDR_W'($urandom_range(0, DEPTH - 1));
         bus.D     = WIDTH'($urandom);
         bus.Start = ($urandom_range(0, 7) == 0);
         bus.Ready = ($urandom_range(0, 3) != 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
